// File: rtl/im_sync.sv
// Loadable instruction memory: valid/ready program load port, 1-cycle registered fetch.
// Optional per-word even parity check when IM_PARITY_EN is defined.
module im_sync #(
  parameter int               ADDR_W    = 8,
  parameter int               DATA_W    = 16,
  parameter int               DEPTH     = 256,
  parameter logic [DATA_W-1:0] HALT_WORD = 16'h0800
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] iout,
  output logic              busy,
  output logic              parity_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];

`ifdef IM_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   prog_len_q, prog_len_d;
  logic              done_q, done_d;
  logic              fv_q;
  logic [DATA_W-1:0] iout_q, iout_d;
  logic              perr_q, perr_d;
  logic              we;
  logic [MW-1:0]     wr_word;
  logic [MW-1:0]     rd_raw;
  logic              hit;

  logic [MW-1:0] mem_q [DEPTH];

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    prog_len_d = prog_len_q;
    done_d     = 1'b0;
    we         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_en) begin
          state_d    = S_LOAD;
          wr_ptr_d   = '0;
          prog_len_d = '0;
        end
      end
      S_LOAD: begin
        if (load_valid) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
        // A full memory ends the load even while load_en stays high
        if (we && wr_ptr_d == DEPTH_W) begin
          state_d    = S_RUN;
          prog_len_d = DEPTH_W;
          done_d     = 1'b1;
        end else if (!load_en) begin
          state_d    = S_RUN;
          prog_len_d = wr_ptr_d;
          done_d     = 1'b1;
        end
      end
      S_RUN: begin
        if (load_en) begin
          state_d    = S_LOAD;
          wr_ptr_d   = '0;
          prog_len_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef IM_PARITY_EN
  assign wr_word = {^load_data, load_data};
`else
  assign wr_word = load_data;
`endif

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_word;
    end
  end

  // Fetch decision sees state and program length from before this edge
  always_comb begin
    rd_raw = mem_q[fetch_addr];
    hit    = (state_q == S_RUN) && ({1'b0, fetch_addr} < prog_len_q);
`ifdef IM_PARITY_EN
    perr_d = hit && ((^rd_raw[DATA_W-1:0]) != rd_raw[DATA_W]);
    iout_d = (hit && !perr_d) ? rd_raw[DATA_W-1:0] : HALT_WORD;
`else
    perr_d = 1'b0;
    iout_d = hit ? rd_raw : HALT_WORD;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      prog_len_q <= '0;
      done_q     <= 1'b0;
      fv_q       <= 1'b0;
      iout_q     <= HALT_WORD;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      prog_len_q <= prog_len_d;
      done_q     <= done_d;
      fv_q       <= fetch_req;
      perr_q     <= fetch_req & perr_d;
      if (fetch_req) begin
        iout_q <= iout_d;
      end
    end
  end

  assign load_ready  = (state_q == S_LOAD);
  assign load_done   = done_q;
  assign busy        = (state_q != S_RUN);
  assign fetch_valid = fv_q;
  assign iout        = iout_q;
`ifdef IM_PARITY_EN
  assign parity_err  = perr_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_im_sync.sv
// Directed bench for im_sync: fetch vector table plus load/reload/full/reset sequences.
module tb_im_sync;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_en;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic        load_done;
  logic        fetch_req;
  logic [7:0]  fetch_addr;
  logic        fetch_valid;
  logic [15:0] iout;
  logic        busy;
  logic        parity_err;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic        req;
    logic [7:0]  addr;
    logic        exp_valid;
    logic [15:0] exp_iout;
  } vec_t;

  vec_t tbl [7];

  always #5 clock = ~clock;

  im_sync dut (
    .clock       (clock),
    .reset       (reset),
    .load_en     (load_en),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_valid (fetch_valid),
    .iout        (iout),
    .busy        (busy),
    .parity_err  (parity_err)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fetch(input logic [7:0] a, input logic [15:0] exp,
                       input string name);
    fetch_req  = 1'b1;
    fetch_addr = a;
    tick();
    fetch_req  = 1'b0;
    chk({name, ".valid"}, 32'(fetch_valid), 32'd1);
    chk({name, ".iout"}, 32'(iout), 32'(exp));
    chk({name, ".perr"}, 32'(parity_err), 32'd0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'd0,   1'b1, 16'hA1B2};
    tbl[1] = '{1'b1, 8'd1,   1'b1, 16'hC3D4};
    tbl[2] = '{1'b1, 8'd2,   1'b1, 16'hE5F6};
    tbl[3] = '{1'b0, 8'd0,   1'b0, 16'hE5F6};
    tbl[4] = '{1'b1, 8'd3,   1'b1, 16'h0800};
    tbl[5] = '{1'b1, 8'd255, 1'b1, 16'h0800};
    tbl[6] = '{1'b1, 8'd1,   1'b1, 16'hC3D4};

    reset = 1'b1; load_en = 1'b0; load_valid = 1'b0; load_data = '0;
    fetch_req = 1'b0; fetch_addr = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst.fv",    32'(fetch_valid), 32'd0);
    chk("rst.iout",  32'(iout),        32'h0800);
    chk("rst.ready", 32'(load_ready),  32'd0);
    chk("rst.done",  32'(load_done),   32'd0);
    chk("rst.busy",  32'(busy),        32'd1);
    chk("rst.perr",  32'(parity_err),  32'd0);

    // T1
    fetch(8'd0, 16'h0800, "t1");
    chk("t1.busy", 32'(busy), 32'd1);

    // T2 load three words
    load_en = 1'b1;
    tick();
    chk("t2.ready", 32'(load_ready), 32'd1);
    load_valid = 1'b1;
    load_data = 16'hA1B2; tick();
    load_data = 16'hC3D4; tick();
    load_data = 16'hE5F6; tick();
    load_valid = 1'b0; load_en = 1'b0;
    chk("t2.nodone", 32'(load_done), 32'd0);
    tick();
    chk("t2.done",  32'(load_done), 32'd1);
    chk("t2.busy",  32'(busy),      32'd0);
    tick();
    chk("t2.done1", 32'(load_done), 32'd0);

    // T2/T3 fetch table, back-to-back
    for (int i = 0; i < 7; i++) begin
      fetch_req  = tbl[i].req;
      fetch_addr = tbl[i].addr;
      tick();
      chk($sformatf("tbl%0d.valid", i), 32'(fetch_valid),
          32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d.iout", i), 32'(iout), 32'(tbl[i].exp_iout));
    end
    fetch_req = 1'b0;

    // T5 reload with simultaneous fetch returns old word
    load_en = 1'b1;
    fetch_req = 1'b1; fetch_addr = 8'd1;
    tick();
    chk("t5.old",   32'(iout),       32'hC3D4);
    chk("t5.busy",  32'(busy),       32'd1);
    chk("t5.ready", 32'(load_ready), 32'd1);
    fetch_req = 1'b0;
    fetch(8'd1, 16'h0800, "t5.inload");
    load_en = 1'b0;
    tick();
    chk("t5.edone", 32'(load_done), 32'd1);
    fetch(8'd0, 16'h0800, "t5.empty");

    // Word accepted in the same cycle load_en drops is counted
    load_en = 1'b1;
    tick();
    load_valid = 1'b1; load_data = 16'h1234; load_en = 1'b0;
    tick();
    load_valid = 1'b0;
    chk("last.done", 32'(load_done), 32'd1);
    fetch(8'd0, 16'h1234, "last.w0");
    fetch(8'd1, 16'h0800, "last.w1");

    // T4 full 256-word load with load_en held high
    load_en = 1'b1;
    tick();
    load_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      load_data = {8'(i), ~8'(i)};
      if (i == 255) begin
        fetch_req = 1'b1; fetch_addr = 8'd7;
      end
      tick();
      if (i == 255) begin
        chk("t4.inload", 32'(iout), 32'h0800);
      end
    end
    chk("t4.ready", 32'(load_ready), 32'd0);
    chk("t4.done",  32'(load_done),  32'd1);
    chk("t4.busy",  32'(busy),       32'd0);
    load_en = 1'b0; load_valid = 1'b0;
    fetch(8'd255, 16'hFF00, "t4.w255");
    fetch(8'd0,   16'h00FF, "t4.w0");
    fetch(8'd128, 16'h807F, "t4.w128");

`ifdef IM_PARITY_EN
    // T6 corrupt one stored bit of address 0
    dut.mem_q[0] = dut.mem_q[0] ^ 17'd1;
    fetch_req = 1'b1; fetch_addr = 8'd0;
    tick();
    fetch_req = 1'b0;
    chk("t6.perr", 32'(parity_err), 32'd1);
    chk("t6.iout", 32'(iout),       32'h0800);
    fetch(8'd1, 16'h01FE, "t6.clean");
`endif

    // Reset mid-load aborts the program
    load_en = 1'b1;
    tick();
    load_valid = 1'b1; load_data = 16'hBEEF;
    tick();
    load_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0; load_en = 1'b0;
    tick();
    chk("rml.busy", 32'(busy),      32'd1);
    chk("rml.done", 32'(load_done), 32'd0);
    fetch(8'd0, 16'h0800, "rml.f0");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
